// File: rtl/rr_select_encoder.sv
// rr_select_encoder: 4-channel round-robin arbiter emitting a binary select index with hold timeout and a dead gap between grants.
module rr_select_encoder #(
  parameter int CNT_W    = 4,
  parameter int HOLD_MAX = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel_idx,
  output logic       sel_valid,
  output logic       hold_expired
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(HOLD_MAX - 1);
  state_t state;
  logic [1:0] last_ptr, pick, c;
  logic [CNT_W-1:0] hold_cnt;
  logic timeout, rel;
  // Scan offsets from farthest to nearest so the channel right after last_ptr wins.
  always_comb begin
    pick = last_ptr;
    c = last_ptr;
    for (int i = 4; i >= 1; i--) begin
      c = last_ptr + 2'(i);
      pick = req[c] ? c : pick;
    end
  end
  assign timeout = (HOLD_MAX != 0) && (hold_cnt == LIM);
  assign rel = done || !req[sel_idx] || timeout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_idx <= 2'b00;
      sel_valid <= 1'b0;
      hold_expired <= 1'b0;
      last_ptr <= 2'b11;
      hold_cnt <= '0;
    end else begin
      hold_expired <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          sel_idx <= pick;
          sel_valid <= 1'b1;
          hold_cnt <= '0;
          state <= GRANT;
        end
        GRANT: if (rel) begin
          sel_valid <= 1'b0;
          last_ptr <= sel_idx;
          hold_cnt <= '0;
          hold_expired <= !done && req[sel_idx];
          state <= GAP;
        end else hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_select_encoder.sv
// tb_rr_select_encoder: directed table and sequence checks for the round-robin select encoder.
module tb_rr_select_encoder;
  logic clk = 1'b0, rst_n = 1'b0, done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel_idx, sel_idx0;
  logic sel_valid, hold_expired, sel_valid0, hold_expired0;
  int errors = 0, checks = 0;
  typedef struct {
    logic [3:0] req;
    logic done;
    logic [1:0] idx;
    logic v;
    logic ex;
  } vec_t;
  vec_t tbl[30];

  always #5 clk = ~clk;

  rr_select_encoder #(.CNT_W(4), .HOLD_MAX(12)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel_idx(sel_idx), .sel_valid(sel_valid), .hold_expired(hold_expired)
  );
  rr_select_encoder #(.CNT_W(4), .HOLD_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel_idx(sel_idx0), .sel_valid(sel_valid0), .hold_expired(hold_expired0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk3(input string nm, input logic [1:0] idx, input logic v, input logic ex);
    check({nm, ".idx"}, 32'(sel_idx), 32'(idx));
    check({nm, ".valid"}, 32'(sel_valid), 32'(v));
    check({nm, ".expired"}, 32'(hold_expired), 32'(ex));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Round robin: each grant valid 4 cycles, done on the 4th, then GAP and IDLE.
    for (int g = 0; g < 5; g++)
      for (int r = 0; r < 6; r++)
        tbl[g*6+r] = '{req: 4'b1111, done: (r == 4), idx: 2'(g % 4), v: (r < 4), ex: 1'b0};

    @(negedge clk);
    do_reset();
    chk3("reset", 2'd0, 1'b0, 1'b0);
    done = 1'b1;
    step();
    chk3("idle_no_req_done", 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    step();
    chk3("idle_no_req", 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      req = tbl[i].req;
      done = tbl[i].done;
      step();
      chk3($sformatf("rr[%0d]", i), tbl[i].idx, tbl[i].v, tbl[i].ex);
    end

    // Timeout on lone request to channel 2.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      chk3($sformatf("to_hold[%0d]", i), 2'd2, 1'b1, 1'b0);
    end
    step();
    chk3("to_fall", 2'd2, 1'b0, 1'b1);
    step();
    chk3("to_gap", 2'd2, 1'b0, 1'b0);
    step();
    chk3("to_regrant", 2'd2, 1'b1, 1'b0);

    // Dropped request releases without a pulse; next grant skips past channel 1.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk3($sformatf("drop_hold[%0d]", i), 2'd1, 1'b1, 1'b0);
    end
    req = 4'b1001;
    step();
    chk3("drop_fall", 2'd1, 1'b0, 1'b0);
    step();
    chk3("drop_gap", 2'd1, 1'b0, 1'b0);
    step();
    chk3("drop_next", 2'd3, 1'b1, 1'b0);

    // done coincident with the last timeout cycle wins.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 12; i++) step();
    chk3("dto_last", 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk3("dto_fall", 2'd2, 1'b0, 1'b0);
    done = 1'b0;

    // Async reset mid-grant; requests changing in GRANT leave sel_idx alone.
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b1111;
    step();
    step();
    chk3("rst_pre", 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk3("rst_async", 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk3("rst_first", 2'd0, 1'b1, 1'b0);

    // HOLD_MAX=0: grant never times out.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("nto_valid[%0d]", i), 32'(sel_valid0), 32'd1);
      check($sformatf("nto_idx[%0d]", i), 32'(sel_idx0), 32'd0);
      check($sformatf("nto_exp[%0d]", i), 32'(hold_expired0), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
